audio_rx: RTL

AUDIO_RX -- requirements
Module: audio_rx

---
 rtl/audio_rx.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/audio_rx.sv
// audio_rx: serial codec receiver. It synchronises the codec frame clock, bit clock
// and data, assembles MSB-first words, pairs left and right words into stereo
// samples and hands them to the consumer with a valid/ack handshake.
// Optional feature: define AUDIO_RX_PEAK_EN to enable the peak-magnitude tracker.
`timescale 1ns/100ps
module audio_rx #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_en,
    input  logic                audio_lr,
    input  logic                audio_clk,
    input  logic                audio_adc_data,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic                sample_valid,
    input  logic                sample_ack,
    output logic                overrun,
    output logic                frame_err,
    input  logic                err_clear,
    output logic [SAMPLE_W-2:0] peak,
    input  logic                peak_clear
);
    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLE_W);

    // Synchroniser stages (meta -> r -> rr) and a fill marker
    logic lr_meta_q, lr_r_q, lr_rr_q;
    logic bclk_meta_q, bclk_r_q, bclk_rr_q;
    logic dat_meta_q, dat_r_q;
    logic [2:0] fill_q;
    logic frame_edge, bit_strobe;

    // Capture stage
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic                armed_q, armed_d;
    logic                commit_vld_q, commit_vld_d;
    logic [SAMPLE_W-1:0] commit_word_q, commit_word_d;
    logic                commit_ch_q, commit_ch_d;
    logic                short_err;

    // Pairing / output stage
    logic                pend_l_q, pend_l_d;
    logic [SAMPLE_W-1:0] pend_word_q, pend_word_d;
    logic [SAMPLE_W-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
    logic                valid_q, valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic                pair_commit, orphan_err;

    // Two-flop synchronisers plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            lr_meta_q   <= 1'b0; lr_r_q   <= 1'b0; lr_rr_q   <= 1'b0;
            bclk_meta_q <= 1'b0; bclk_r_q <= 1'b0; bclk_rr_q <= 1'b0;
            dat_meta_q  <= 1'b0; dat_r_q  <= 1'b0;
            fill_q      <= '0;
        end else begin
            lr_meta_q   <= audio_lr;       lr_r_q   <= lr_meta_q;   lr_rr_q   <= lr_r_q;
            bclk_meta_q <= audio_clk;      bclk_r_q <= bclk_meta_q; bclk_rr_q <= bclk_r_q;
            dat_meta_q  <= audio_adc_data; dat_r_q  <= dat_meta_q;
            fill_q      <= {fill_q[1:0], 1'b1};
        end
    end

    // Reset zeroes the sync chain; a high pin would then look like an edge. Edges are
    // only trusted once every stage holds a real pin sample, so reset cannot arm capture.
    assign frame_edge = fill_q[2] & (lr_r_q ^ lr_rr_q);
    assign bit_strobe = fill_q[2] & bclk_r_q & ~bclk_rr_q;

    // Word assembly: shift bits, count them, decide commit or short word at frame edges
    always_comb begin
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        armed_d       = armed_q;
        commit_vld_d  = 1'b0;
        commit_word_d = commit_word_q;
        commit_ch_d   = commit_ch_q;
        short_err     = 1'b0;
        if (!rx_en) begin
            cnt_d   = '0;
            armed_d = 1'b0;
        end else begin
            if (frame_edge) begin
                if (armed_q) begin
                    if (cnt_q == FULL_CNT) begin
                        commit_vld_d  = 1'b1;
                        commit_word_d = shift_q;
                        commit_ch_d   = lr_rr_q;
                    end else begin
                        short_err = 1'b1;
                    end
                end
                armed_d = 1'b1;
                cnt_d   = '0;
            end
            // A strobe coinciding with the frame edge is bit 0 of the new word
            if (bit_strobe && (frame_edge || cnt_q != FULL_CNT)) begin
                shift_d = {shift_q[SAMPLE_W-2:0], dat_r_q};
                cnt_d   = frame_edge ? CNT_W'(1) : cnt_q + 1'b1;
            end
        end
    end

    // Capture-stage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            shift_q       <= '0;
            armed_q       <= 1'b0;
            commit_vld_q  <= 1'b0;
            commit_word_q <= '0;
            commit_ch_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            armed_q       <= armed_d;
            commit_vld_q  <= commit_vld_d;
            commit_word_q <= commit_word_d;
            commit_ch_q   <= commit_ch_d;
        end
    end

    // Pairing, handshake and sticky error flags
    always_comb begin
        pend_l_d    = pend_l_q;
        pend_word_d = pend_word_q;
        sample_l_d  = sample_l_q;
        sample_r_d  = sample_r_q;
        valid_d     = valid_q;
        pair_commit = 1'b0;
        orphan_err  = 1'b0;
        if (!rx_en) begin
            pend_l_d = 1'b0;
        end else if (commit_vld_q) begin
            if (!commit_ch_q) begin
                pend_l_d    = 1'b1;
                pend_word_d = commit_word_q;
            end else if (pend_l_q) begin
                pair_commit = 1'b1;
                pend_l_d    = 1'b0;
                sample_l_d  = pend_word_q;
                sample_r_d  = commit_word_q;
            end else begin
                orphan_err = 1'b1;
            end
        end
        if (pair_commit) begin
            valid_d = 1'b1;
        end else if (sample_ack) begin
            valid_d = 1'b0;
        end
        // A set in the same cycle as err_clear wins
        overrun_d   = (pair_commit & valid_q & ~sample_ack) | (overrun_q & ~err_clear);
        frame_err_d = short_err | orphan_err | (frame_err_q & ~err_clear);
    end

    // Output-stage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_l_q    <= 1'b0;
            pend_word_q <= '0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            pend_l_q    <= pend_l_d;
            pend_word_q <= pend_word_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign frame_err    = frame_err_q;

`ifdef AUDIO_RX_PEAK_EN
    // Magnitude of a two's complement word; the most negative value saturates
    function automatic logic [SAMPLE_W-2:0] mag_of(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] neg;
        neg = -x;
        if (!x[SAMPLE_W-1]) return x[SAMPLE_W-2:0];
        if (x[SAMPLE_W-2:0] == '0) return '1;
        return neg[SAMPLE_W-2:0];
    endfunction

    logic [SAMPLE_W-2:0] peak_q, peak_d, mag_l, mag_r, pair_mag;
    assign mag_l    = mag_of(pend_word_q);
    assign mag_r    = mag_of(commit_word_q);
    assign pair_mag = (mag_l > mag_r) ? mag_l : mag_r;

    // Peak tracker: running maximum over committed pairs
    always_comb begin
        peak_d = peak_q;
        if (peak_clear) begin
            peak_d = pair_commit ? pair_mag : '0;
        end else if (pair_commit && pair_mag > peak_q) begin
            peak_d = pair_mag;
        end
    end

    // Peak register
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`else
    logic unused_peak_clear;
    assign unused_peak_clear = peak_clear;
    assign peak = '0;
`endif

endmodule
